penguin_collision_probe: RTL and testbench
==========================================

// Module: penguin_collision_probe
// PURPOSE
//  Sequential, parametrised successor to the single-direction wall check. On a start
//  strobe it latches the penguin position and probes the kitchen tile map in all
//  four directions (UP, DOWN, LEFT, RIGHT) through a req/ack map-read port. It then
//  publishes per-direction touch flags and nearest-counter tile origins.
//  Sits between the penguin motion logic (start = frame tick) and the counter map ROM.
// PARAMETERS
//  COORD_W  10   pixel coordinate width
//  TILE     40   tile edge, pixels (any value >= 2, need not be a power of two)
//  GRID_X0  20   pixel X of tile column 0 left edge
//  GRID_Y0  100  pixel Y of tile row 0 top edge
//  COLS     15   tile columns
//  ROWS     9    tile rows
//  PENG_W   40   penguin sprite width, pixels
//  PENG_H   40   penguin sprite height, pixels
// PORTS
//  Clk         in   1        system clock
//  Reset_n     in   1        asynchronous, active-low reset
//  start       in   1        pulse: begin a probe pass (ignored while busy)
//  penguinX    in   COORD_W  penguin top-left X, sampled on accepted start
//  penguinY    in   COORD_W  penguin top-left Y, sampled on accepted start
//  busy        out  1        pass in progress
//  done        out  1        one-cycle pulse: result outputs updated this cycle
//  map_req     out  1        map read request, held until map_ack
//  map_col     out  CW       tile column, CW=$clog2(COLS); stable while map_req
//  map_row     out  RW       tile row, RW=$clog2(ROWS); stable while map_req
//  map_ack     in   1        map read complete; map_solid valid this cycle
//  map_solid   in   1        1 = tile is a counter/wall
//  touch       out  4        {RIGHT,LEFT,DOWN,UP} blocked flags
//  nearX       out  4*COORD_W  per-direction counter tile X origin, same bit order
//  nearY       out  4*COORD_W  per-direction counter tile Y origin
// BEHAVIOUR
//  - Reset (async): state IDLE; busy, done, map_req, touch = 0; nearX, nearY, map_col, map_row = 0.
//  - FSM: IDLE -> LATCH -> PROBE (one probe per direction, order UP,DOWN,LEFT,RIGHT) -> DONE -> IDLE.
//  - IDLE: start=1 -> LATCH; X/Y captured; busy=1 from the next cycle.
//  - Probe points: UP (X, Y-1); DOWN (X, Y+PENG_H); LEFT (X-1, Y); RIGHT (X+PENG_W, Y).
//  - Arithmetic: col=(px-GRID_X0)/TILE, row=(py-GRID_Y0)/TILE, computed at COORD_W+1 bits.
//  - Out-of-bounds probe: px<GRID_X0, py<GRID_Y0, col>=COLS, row>=ROWS, or X-1/Y-1 underflow.
//    -> no map read; direction touch=1; nearX/nearY = 0.
//  - In-bounds probe: assert map_req with col/row. Result taken on the cycle map_ack=1.
//    map_solid=1 -> touch=1, nearX=GRID_X0+col*TILE, nearY=GRID_Y0+row*TILE.
//    map_solid=0 -> touch=0, near=0.
//  - map_req drops the cycle after ack. Back-to-back req is allowed.
//    ack while map_req=0 is ignored. No timeout; map must eventually ack.
//  - Results accumulate in shadow registers. touch/nearX/nearY update together in DONE, with done=1 for one cycle.
//  - Outputs hold until the next DONE. busy clears in DONE.
//  - Latency with map_ack tied high: start at cycle t -> done at t+6.
//    Each map wait cycle adds 1. Out-of-bounds probes cost 1 cycle each.
//  - start during busy or DONE: ignored, not queued.
//  - Reset_n low mid-pass: immediate abort; map_req=0; outputs return to reset values.
// CONFIGURATION
//  COLLIDE_CORNER_EN defined:
//    - Each direction makes two probes: the second at the opposite edge corner.
//      UP/DOWN use X+PENG_W-1; LEFT/RIGHT use Y+PENG_H-1.
//    - touch = OR of both probes; near* comes from the first solid probe.
//    - Out-of-bounds rule applies per probe. Tied-high latency becomes t+10.
//  Undefined: single probe per direction, as above.
// TESTING
//  1 X=100,Y=140, map all solid, ack tied 1
//    -> UP reads col2,row0; touch[0]=1, near UP=(100,100); done at t+6.
//  2 X=100,Y=180, only tile(2,3) solid
//    -> DOWN probe Y=220 row3; touch=4'b0010, near DOWN=(100,220), others 0.
//  3 X=20,Y=200, map empty
//    -> LEFT probe X=19 out of bounds; touch=4'b0100, near LEFT=(0,0), no map_req for LEFT.
//  4 map_ack delayed 3 cycles per read
//    -> map_col/row stable while req; done at t+18.
//    -> start pulses during busy produce no second done.
//  5 Reset_n low while map_req=1 -> map_req, busy, touch = 0 asynchronously.
//    -> next start after release runs a clean pass.
//  6 COLLIDE_CORNER_EN, X=90,Y=140, only tile(2,0) solid
//    -> UP corner probes X=90 (col1) then X=129 (col2); touch[0]=1, near UP=(100,100).

Source files
------------

// File: rtl/penguin_collision_probe.sv
// penguin_collision_probe: probes the tile map UP, DOWN, LEFT, RIGHT around the penguin via req/ack.
// Define COLLIDE_CORNER_EN to add a second, opposite-corner probe per direction.
module penguin_collision_probe #(
    parameter int COORD_W = 10,
    parameter int TILE    = 40,
    parameter int GRID_X0 = 20,
    parameter int GRID_Y0 = 100,
    parameter int COLS    = 15,
    parameter int ROWS    = 9,
    parameter int PENG_W  = 40,
    parameter int PENG_H  = 40,
    localparam int CW     = $clog2(COLS),
    localparam int RW     = $clog2(ROWS)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [COORD_W-1:0]   penguinX,
    input  logic [COORD_W-1:0]   penguinY,
    output logic                 busy,
    output logic                 done,
    output logic                 map_req,
    output logic [CW-1:0]        map_col,
    output logic [RW-1:0]        map_row,
    input  logic                 map_ack,
    input  logic                 map_solid,
    output logic [3:0]           touch,
    output logic [4*COORD_W-1:0] nearX,
    output logic [4*COORD_W-1:0] nearY
);
`ifdef COLLIDE_CORNER_EN
    localparam int PW = 3;
`else
    localparam int PW = 2;
`endif
    localparam int NP = 1 << PW;
    localparam int XW = COORD_W + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_LATCH = 2'd1, S_PROBE = 2'd2, S_DONE = 2'd3;

    typedef struct packed {
        logic          oob;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } probe_t;

    // Probe index p: upper bits select the direction, the LSB (corner build only) the far corner.
    function automatic probe_t probe_at(input logic [PW-1:0] p, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        logic [1:0]    d;
        logic          c;
        logic          under;
        logic [XW-1:0] px, py, cx, ry;
        probe_t        r;
        d = 2'(p >> (PW - 2));
        c = (PW == 3) ? p[0] : 1'b0;
        px = {1'b0, x};
        py = {1'b0, y};
        if (c) begin
            if (d[1]) py = py + XW'(PENG_H - 1);
            else px = px + XW'(PENG_W - 1);
        end
        under = (d == 2'd0 && y == '0) || (d == 2'd2 && x == '0);
        case (d)
            2'd0:    py = py - XW'(1);
            2'd1:    py = py + XW'(PENG_H);
            2'd2:    px = px - XW'(1);
            default: px = px + XW'(PENG_W);
        endcase
        cx = (px - XW'(GRID_X0)) / XW'(TILE);
        ry = (py - XW'(GRID_Y0)) / XW'(TILE);
        r.oob = under || px < XW'(GRID_X0) || py < XW'(GRID_Y0) || cx >= XW'(COLS) || ry >= XW'(ROWS);
        r.col = cx[CW-1:0];
        r.row = ry[RW-1:0];
        return r;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        p_q, p_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic                 busy_q, busy_d, done_q, done_d, req_q, req_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [3:0]           ts_q, ts_d, hit_q, hit_d, touch_q, touch_d;
    logic [4*COORD_W-1:0] nxs_q, nxs_d, nys_q, nys_d, nearx_q, nearx_d, neary_q, neary_d;
    logic [1:0]           cur_dir;
    logic                 step, cur_touch, cur_solid;
    logic [COORD_W-1:0]   tile_x, tile_y;
    probe_t               nxt;

    assign cur_dir   = 2'(p_q >> (PW - 2));
    assign step      = state_q == S_PROBE && (!req_q || map_ack);
    assign cur_touch = !req_q || map_solid;
    assign cur_solid = req_q && map_solid;
    assign tile_x    = COORD_W'(GRID_X0) + COORD_W'(TILE) * COORD_W'(col_q);
    assign tile_y    = COORD_W'(GRID_Y0) + COORD_W'(TILE) * COORD_W'(row_q);
    assign nxt       = probe_at(state_q == S_LATCH ? '0 : p_q + PW'(1), x_q, y_q);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        req_d   = req_q;
        col_d   = col_q;
        row_d   = row_q;
        ts_d    = ts_q;
        hit_d   = hit_q;
        nxs_d   = nxs_q;
        nys_d   = nys_q;
        touch_d = touch_q;
        nearx_d = nearx_q;
        neary_d = neary_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LATCH;
                busy_d  = 1'b1;
                x_d     = penguinX;
                y_d     = penguinY;
            end
            S_LATCH: begin
                state_d = S_PROBE;
                p_d     = '0;
                ts_d    = '0;
                hit_d   = '0;
                nxs_d   = '0;
                nys_d   = '0;
                req_d   = !nxt.oob;
                col_d   = nxt.col;
                row_d   = nxt.row;
            end
            S_PROBE: if (step) begin
                ts_d[cur_dir] = ts_q[cur_dir] | cur_touch;
                if (cur_solid && !hit_q[cur_dir]) begin
                    hit_d[cur_dir] = 1'b1;
                    nxs_d[int'(cur_dir) * COORD_W +: COORD_W] = tile_x;
                    nys_d[int'(cur_dir) * COORD_W +: COORD_W] = tile_y;
                end
                if (p_q == PW'(NP - 1)) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    touch_d = ts_d;
                    nearx_d = nxs_d;
                    neary_d = nys_d;
                end else begin
                    p_d   = p_q + PW'(1);
                    req_d = !nxt.oob;
                    col_d = nxt.col;
                    row_d = nxt.row;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ts_q    <= '0;
            hit_q   <= '0;
            nxs_q   <= '0;
            nys_q   <= '0;
            touch_q <= '0;
            nearx_q <= '0;
            neary_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ts_q    <= ts_d;
            hit_q   <= hit_d;
            nxs_q   <= nxs_d;
            nys_q   <= nys_d;
            touch_q <= touch_d;
            nearx_q <= nearx_d;
            neary_q <= neary_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign map_req = req_q;
    assign map_col = col_q;
    assign map_row = row_q;
    assign touch   = touch_q;
    assign nearX   = nearx_q;
    assign nearY   = neary_q;
endmodule

// File: tb/tb_penguin_collision_probe.sv
// tb_penguin_collision_probe: directed passes with a map responder and a done-driven scoreboard monitor.
module tb_penguin_collision_probe;
    localparam int W = 10;

    logic           Clk = 1'b0, Reset_n = 1'b0, start = 1'b0;
    logic [W-1:0]   penguinX = '0, penguinY = '0;
    logic           busy, done, map_req, map_ack = 1'b0, map_solid = 1'b0;
    logic [3:0]     map_col, map_row, touch;
    logic [4*W-1:0] nearX, nearY;

    always #5 Clk = ~Clk;

    penguin_collision_probe dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .penguinX(penguinX), .penguinY(penguinY),
        .busy(busy), .done(done), .map_req(map_req), .map_col(map_col), .map_row(map_row),
        .map_ack(map_ack), .map_solid(map_solid), .touch(touch), .nearX(nearX), .nearY(nearY)
    );

    typedef struct {
        logic [3:0]     touch;
        logic [4*W-1:0] nx, ny;
        int             lat, reads;
        string          name;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         compared = 0, mismatched = 0;
    int         cyc = 0, start_cyc = 0, reads = 0, ack_delay = 0, wait_cnt = 0;
    bit         ack_tied = 1'b1;
    bit         solid [15][9];
    logic       preq = 1'b0, pack = 1'b0;
    logic [3:0] pcol = '0, prow = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] t, input logic [4*W-1:0] nx, input logic [4*W-1:0] ny,
                                input int lat, input int rd, input string nm);
        exp_t e;
        e.touch = t;
        e.nx = nx;
        e.ny = ny;
        e.lat = lat;
        e.reads = rd;
        e.name = nm;
        return e;
    endfunction

    task automatic set_map(input bit v);
        for (int c = 0; c < 15; c++)
            for (int r = 0; r < 9; r++)
                solid[c][r] = v;
    endtask

    // Map ROM model: answers after ack_delay wait cycles, or acks every cycle when tied high.
    always @(negedge Clk) begin
        if (map_req && preq && !pack) begin
            check("map_col_stable", map_col, pcol);
            check("map_row_stable", map_row, prow);
        end
        map_ack = ack_tied || (map_req && wait_cnt == ack_delay);
        wait_cnt = (!ack_tied && map_req && !map_ack) ? wait_cnt + 1 : 0;
        map_solid = (map_col < 15 && map_row < 9) ? solid[map_col][map_row] : 1'b0;
        if (map_req && map_ack) reads++;
        preq = map_req;
        pack = map_ack;
        pcol = map_col;
        prow = map_row;
    end

    always @(negedge Clk) begin
        if (Reset_n && done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 with no pass pending, required done=0");
            end else begin
                cur = sb.pop_front();
                check({cur.name, "_touch"}, touch, cur.touch);
                check({cur.name, "_nearX"}, nearX, cur.nx);
                check({cur.name, "_nearY"}, nearY, cur.ny);
                check({cur.name, "_latency"}, cyc - start_cyc, cur.lat);
                check({cur.name, "_reads"}, reads, cur.reads);
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        @(negedge Clk);
        penguinX = x;
        penguinY = y;
        start = 1'b1;
        start_cyc = cyc;
        reads = 0;
        sb.push_back(e);
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no done within 200 cycles, required done", name);
            sb.delete();
        end
        repeat (10) @(negedge Clk);
    endtask

    task automatic pulse_start;
        penguinX = '0;
        penguinY = '0;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_map(1'b0);
        repeat (2) @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_map_req", map_req, 0);
        check("rst_map_colrow", {map_col, map_row}, 0);
        check("rst_touch", touch, 0);
        check("rst_near", {nearX, nearY}, 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
`ifdef COLLIDE_CORNER_EN
        set_map(1'b0);
        solid[2][0] = 1'b1;
        issue(90, 140, mk(4'b0001, {30'd0, 10'd100}, {30'd0, 10'd100}, 10, 8, "corner_up"));
        drain("corner_up");
        set_map(1'b1);
        issue(0, 0, mk(4'b1111, '0, '0, 10, 0, "corner_origin"));
        drain("corner_origin");
        set_map(1'b0);
        issue(20, 200, mk(4'b0100, '0, '0, 10, 6, "corner_left_edge"));
        drain("corner_left_edge");
`else
        set_map(1'b1);
        issue(100, 140, mk(4'b1111, {10'd140, 10'd60, 10'd100, 10'd100},
                           {10'd140, 10'd140, 10'd180, 10'd100}, 6, 4, "all_solid"));
        drain("all_solid");
        set_map(1'b0);
        solid[2][3] = 1'b1;
        issue(100, 180, mk(4'b0010, {20'd0, 10'd100, 10'd0}, {20'd0, 10'd220, 10'd0}, 6, 4, "down_only"));
        drain("down_only");
        set_map(1'b0);
        issue(20, 200, mk(4'b0100, '0, '0, 6, 3, "left_oob"));
        drain("left_oob");
        set_map(1'b1);
        issue(0, 0, mk(4'b1111, '0, '0, 6, 0, "origin_oob"));
        drain("origin_oob");
        issue(580, 420, mk(4'b1111, {10'd0, 10'd540, 10'd0, 10'd580},
                           {10'd0, 10'd420, 10'd0, 10'd380}, 6, 2, "bottom_right"));
        drain("bottom_right");
        ack_tied = 1'b0;
        ack_delay = 3;
        set_map(1'b0);
        solid[1][1] = 1'b1;
        issue(100, 140, mk(4'b0100, {10'd0, 10'd60, 20'd0}, {10'd0, 10'd140, 20'd0}, 18, 4, "delayed"));
        @(negedge Clk);
        pulse_start();
        repeat (6) @(negedge Clk);
        pulse_start();
        for (int n = 0; n < 40 && !done; n++) @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        drain("delayed");
`endif
        ack_tied = 1'b0;
        ack_delay = 3;
        issue(100, 140, mk('0, '0, '0, 0, 0, "aborted"));
        @(negedge Clk);
        check("req_before_reset", map_req, 1);
        #1 Reset_n = 1'b0;
        #1;
        check("abort_map_req", map_req, 0);
        check("abort_busy", busy, 0);
        check("abort_touch", touch, 0);
        check("abort_near", {nearX, nearY}, 0);
        sb.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        ack_tied = 1'b1;
        @(negedge Clk);
`ifdef COLLIDE_CORNER_EN
        set_map(1'b0);
        solid[2][0] = 1'b1;
        issue(90, 140, mk(4'b0001, {30'd0, 10'd100}, {30'd0, 10'd100}, 10, 8, "after_reset"));
`else
        set_map(1'b1);
        issue(100, 140, mk(4'b1111, {10'd140, 10'd60, 10'd100, 10'd100},
                           {10'd140, 10'd140, 10'd180, 10'd100}, 6, 4, "after_reset"));
`endif
        drain("after_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
